// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 definitions: word type, rotation amounts, round index tables,
// state pack/unpack helpers and the block constants.
package chacha20_pkg;

  localparam int N = 32;

  localparam int ROT_16 = 16;
  localparam int ROT_12 = 12;
  localparam int ROT_8  = 8;
  localparam int ROT_7  = 7;

  typedef logic [N-1:0] word_t;
  typedef word_t [15:0] words_t;
  typedef logic [3:0]   idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_state_e;

  // Each row is one (a, b, c, d) quarter-round group.
  localparam idx_t COLUMN_IDX [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam idx_t DIAGONAL_IDX [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  localparam word_t SIGMA [4] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574
  };

  function automatic words_t unpack_state(input logic [16*N-1:0] s);
    words_t w;
    for (int i = 0; i < 16; i++) begin
      w[i] = s[N*i +: N];
    end
    return w;
  endfunction

  function automatic logic [16*N-1:0] pack_state(input words_t w);
    logic [16*N-1:0] s;
    for (int i = 0; i < 16; i++) begin
      s[N*i +: N] = w[i];
    end
    return s;
  endfunction

endpackage

// File: rtl/chacha20_quarter_inv.sv
// Combinational inverse ChaCha20 quarter-round: undoes the forward steps in
// reverse order, with subtraction and right rotation replacing add and left rotation.
module chacha20_quarter_inv
  import chacha20_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_out,
  output word_t b_out,
  output word_t c_out,
  output word_t d_out
);

  function automatic word_t rotr(input word_t x, input int r);
    return (x >> r) | (x << (N - r));
  endfunction

  word_t a1, b1, c1, d1;

  always_comb begin
    b1    = rotr(b, ROT_7) ^ c;
    c1    = c - d;
    d1    = rotr(d, ROT_8) ^ a;
    a1    = a - b1;
    b_out = rotr(b1, ROT_12) ^ c1;
    c_out = c1 - d1;
    d_out = rotr(d1, ROT_16) ^ a1;
    a_out = a1 - b_out;
  end

endmodule

// File: rtl/chacha20_block_inverse.sv
// Sequential inverse of the ChaCha20 permutation: one inverse half-round per
// cycle, diagonal on even counts and column on odd counts, one block in flight.
module chacha20_block_inverse #(
  parameter int N      = 32,
  parameter int ROUNDS = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [16*N-1:0] in_state,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [16*N-1:0] out_state,
  output logic            busy
);

  import chacha20_pkg::*;

  localparam int CW = $clog2(ROUNDS);

  fsm_state_e    state, state_next;
  logic [CW-1:0] cnt;
  logic          last;
  words_t        work, work_next;
  idx_t          sel [4][4];
  word_t         q_in  [4][4];
  word_t         q_out [4][4];

  assign last     = (cnt == CW'(ROUNDS - 1));
  assign in_ready = (state == ST_IDLE) && !rst;
  assign busy     = (state != ST_IDLE);

  // Gather each group's four words from the table chosen by the round parity.
  always_comb begin
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        sel[g][k]  = cnt[0] ? COLUMN_IDX[g][k] : DIAGONAL_IDX[g][k];
        q_in[g][k] = work[sel[g][k]];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha20_quarter_inv u_qr (
      .a     (q_in[g][0]),
      .b     (q_in[g][1]),
      .c     (q_in[g][2]),
      .d     (q_in[g][3]),
      .a_out (q_out[g][0]),
      .b_out (q_out[g][1]),
      .c_out (q_out[g][2]),
      .d_out (q_out[g][3])
    );
  end

  // The four groups cover all 16 words exactly once, so every word is rewritten.
  always_comb begin
    work_next = work;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        work_next[sel[g][k]] = q_out[g][k];
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)  state_next = ST_RUN;
      ST_RUN:  if (last)      state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      work      <= '0;
      out_state <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work <= unpack_state(in_state);
            cnt  <= '0;
          end
        end
        ST_RUN: begin
          work <= work_next;
          cnt  <= cnt + 1'b1;
          if (last) begin
            out_state <= pack_state(work_next);
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_block_inverse.sv
// Self-checking bench for chacha20_block_inverse: forward-permutation model,
// scoreboard with per-cycle output compare, directed RFC vectors and handshake cases.
module tb_chacha20_block_inverse;

  localparam int ROUNDS = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT ----------------
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [511:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [511:0] out_state;
  logic         busy;

  chacha20_block_inverse #(.N(32), .ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy)
  );

  // ---------------- short-schedule DUTs ----------------
  logic         aux_ready_tie = 1'b1;
  logic         iv2 = 1'b0, ir2, ov2, busy2;
  logic [511:0] is2 = '0, os2;
  logic         iv8 = 1'b0, ir8, ov8, busy8;
  logic [511:0] is8 = '0, os8;

  chacha20_block_inverse #(.N(32), .ROUNDS(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2), .in_state(is2),
    .out_valid(ov2), .out_ready(aux_ready_tie), .out_state(os2),
    .busy(busy2)
  );

  chacha20_block_inverse #(.N(32), .ROUNDS(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .in_state(is8),
    .out_valid(ov8), .out_ready(aux_ready_tie), .out_state(os8),
    .busy(busy8)
  );

  // ---------------- standalone quarter-round ----------------
  logic [31:0] qa, qb, qc, qd, qa_o, qb_o, qc_o, qd_o;

  chacha20_quarter_inv u_qinv (
    .a(qa), .b(qb), .c(qc), .d(qd),
    .a_out(qa_o), .b_out(qb_o), .c_out(qc_o), .d_out(qd_o)
  );

  // ---------------- counters / check ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: forward permutation ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [127:0] fqr(input logic [127:0] abcd);
    logic [31:0] a, b, c, d;
    {a, b, c, d} = abcd;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] fwd(input logic [511:0] s, input int rounds);
    int col [4][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15}};
    int dia [4][4] = '{'{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    logic [31:0]  w [16];
    logic [127:0] q;
    int           ix [4];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) w[i] = s[32*i +: 32];
    for (int rd = 0; rd < rounds; rd++) begin
      for (int g = 0; g < 4; g++) begin
        for (int k = 0; k < 4; k++) ix[k] = (rd % 2 == 0) ? col[g][k] : dia[g][k];
        q = fqr({w[ix[0]], w[ix[1]], w[ix[2]], w[ix[3]]});
        w[ix[0]] = q[127:96];
        w[ix[1]] = q[95:64];
        w[ix[2]] = q[63:32];
        w[ix[3]] = q[31:0];
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i];
    return r;
  endfunction

  function automatic logic [511:0] pk(input logic [31:0] w [16]);
    logic [511:0] s;
    for (int i = 0; i < 16; i++) s[32*i +: 32] = w[i];
    return s;
  endfunction

  logic [31:0] rfc_in_w [16] = '{
    32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
    32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
    32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
    32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000
  };
  logic [31:0] rfc_out_w [16] = '{
    32'h837778ab, 32'he238d763, 32'ha67ae21e, 32'h5950bb2f,
    32'hc4f2d0c7, 32'hfc62bb2f, 32'h8fa018fc, 32'h3f5ec7b7,
    32'h335271c2, 32'hf29489f3, 32'heabda8fc, 32'h82e46ebd,
    32'hd19c12b4, 32'hb04e16de, 32'h9e83d0cb, 32'h4e3c50a2
  };

  // ---------------- scoreboard / compare process ----------------
  logic [511:0] exp_q [$];
  int           lat_q [$];
  logic [511:0] pending_exp = '0;
  logic         prev_ov = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      lat_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(pending_exp);
        lat_q.push_back(cyc + 1 + ROUNDS);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("out_without_accept", 512'(out_valid), 512'(0));
        end else begin
          if (!prev_ov) chk("latency", 512'(cyc), 512'(lat_q[0]));
          chk("out_state", out_state, exp_q[0]);
          chk("busy_in_done", 512'(busy), 512'(1));
          chk("in_ready_in_done", 512'(in_ready), 512'(0));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [511:0] s, input logic [511:0] e);
    bit got = 1'b0;
    pending_exp = e;
    @(posedge clk); #1;
    in_state = s;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("accept_timeout", 512'(got), 512'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("drain", 512'(exp_q.size()), 512'(0));
  endtask

  task automatic aux_run(input int k, input logic [511:0] s, input logic [511:0] e);
    bit got = 1'b0;
    int lat = 0;
    logic ov, ir;
    logic [511:0] os;
    @(posedge clk); #1;
    if (k == 0) begin is2 = s; iv2 = 1'b1; end
    else        begin is8 = s; iv8 = 1'b1; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ir = (k == 0) ? ir2 : ir8;
      if (ir) begin got = 1'b1; break; end
    end
    @(posedge clk); #1;
    iv2 = 1'b0;
    iv8 = 1'b0;
    chk("aux_accept", 512'(got), 512'(1));
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      ov = (k == 0) ? ov2 : ov8;
      if (ov) break;
    end
    os = (k == 0) ? os2 : os8;
    chk(k == 0 ? "aux2_latency" : "aux8_latency", 512'(lat), 512'(k == 0 ? 2 : 8));
    chk(k == 0 ? "aux2_state" : "aux8_state", os, e);
  endtask

  // ---------------- stimulus ----------------
  logic [511:0] rfc_in, rfc_out, a_st, b_st, orig;
  bit           seen;

  initial begin
    rfc_in  = pk(rfc_in_w);
    rfc_out = pk(rfc_out_w);

    // Model pins: RFC quarter-round and full 20-round block.
    chk("model_qr", 512'(fqr({32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567})),
        512'({32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb}));
    chk("model_block", fwd(rfc_in, 20), rfc_out);

    // Standalone inverse quarter-round.
    qa = 32'hea2a92f4; qb = 32'hcb1cf8ce; qc = 32'h4581472e; qd = 32'h5881c4bb;
    #1;
    chk("qinv_a", 512'(qa_o), 512'(32'h11111111));
    chk("qinv_b", 512'(qb_o), 512'(32'h01020304));
    chk("qinv_c", 512'(qc_o), 512'(32'h9b8d6f43));
    chk("qinv_d", 512'(qd_o), 512'(32'h01234567));

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_out_state", out_state, 512'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 512'(in_ready), 512'(1));

    // RFC full block.
    send(rfc_out, rfc_in);
    drain();
    chk("rfc_w0",  512'(out_state[0*32 +: 32]),  512'(32'h61707865));
    chk("rfc_w1",  512'(out_state[1*32 +: 32]),  512'(32'h3320646e));
    chk("rfc_w2",  512'(out_state[2*32 +: 32]),  512'(32'h79622d32));
    chk("rfc_w3",  512'(out_state[3*32 +: 32]),  512'(32'h6b206574));
    chk("rfc_w12", 512'(out_state[12*32 +: 32]), 512'(32'h00000001));
    chk("rfc_w13", 512'(out_state[13*32 +: 32]), 512'(32'h09000000));

    // All-zero fixed point.
    send('0, '0);
    drain();

    // Backpressure.
    for (int i = 0; i < 16; i++) a_st[32*i +: 32] = $urandom;
    for (int i = 0; i < 16; i++) b_st[32*i +: 32] = $urandom;
    out_ready = 1'b0;
    send(fwd(a_st, 20), a_st);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
    end
    chk("bp_out_valid_rise", 512'(seen), 512'(1));
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin in_state = fwd(b_st, 20); in_valid = 1'b1; end
      if (i == 6) in_valid = 1'b0;
      @(negedge clk);
      chk("bp_hold_valid", 512'(out_valid), 512'(1));
      chk("bp_hold_state", out_state, a_st);
      chk("bp_in_ready", 512'(in_ready), 512'(0));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_valid", 512'(out_valid), 512'(0));
    chk("bp_after_in_ready", 512'(in_ready), 512'(1));
    chk("bp_after_state", out_state, a_st);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_second_ignored", 512'(busy), 512'(0));
    drain();

    // Reset during RUN cycle 7.
    send(fwd(b_st, 20), b_st);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", 512'(out_valid), 512'(0));
    chk("abort_busy", 512'(busy), 512'(0));
    chk("abort_out_state", out_state, 512'(0));
    send(fwd(b_st, 20), b_st);
    drain();
    chk("abort_recovery", out_state, b_st);

    // Random round-trips, back to back.
    for (int t = 0; t < 100; t++) begin
      for (int i = 0; i < 16; i++) orig[32*i +: 32] = $urandom;
      send(fwd(orig, 20), orig);
    end
    drain();

    // Short schedules.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 16; i++) orig[32*i +: 32] = $urandom;
      aux_run(0, fwd(orig, 2), orig);
      for (int i = 0; i < 16; i++) orig[32*i +: 32] = $urandom_range(32'hffffffff, 0);
      aux_run(1, fwd(orig, 8), orig);
    end

    chk("final_queue_empty", 512'(exp_q.size()), 512'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chacha20_block_inverse.md
Name: chacha20_block_inverse

Overview:
- Sequential inverse of the ChaCha20 20-round permutation: takes a 16-word post-round state and recovers the pre-round input state.
- Runs the round schedule backwards: inverse diagonal round, then inverse column round, repeated.
- Used by the verification and key-recovery path to check and undo the core permutation.
- Ready/valid on both ends; one block in flight.

Parameters:
- N, 32, word width in bits; only 32 is supported.
- ROUNDS, 20, number of half-rounds (column or diagonal rounds) to undo; must be even and ≥2.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_state is valid.
- in_ready  out  1  block can accept a state.
- in_state  in  16*N  post-round state; word i = bits [N*i+N-1 : N*i].
- out_valid  out  1  out_state holds a recovered state.
- out_ready  in  1  consumer accepts out_state.
- out_state  out  16*N  recovered pre-round state; same packing as in_state.
- busy  out  1  high in RUN and DONE.

Behaviour:
- Reset: one clock, synchronous, active-high; rst sampled high on a rising edge forces IDLE, out_valid=0, busy=0, out_state=0, round counter=0. in_ready is combinational from state, so it is 0 while rst is high and 1 in the first cycle after reset.
- FSM states are IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid=1, load in_state into the working register, set cnt=0, go to RUN. If in_valid=0, stay in IDLE.
- RUN: in_ready=0. Each cycle applies 4 inverse quarter-rounds in parallel, one half-round per cycle, then cnt++.
  - Even cnt is an inverse diagonal round on index groups (0,5,10,15), (1,6,11,12), (2,7,8,13), (3,4,9,14).
  - Odd cnt is an inverse column round on index groups (0,4,8,12), (1,5,9,13), (2,6,10,14), (3,7,11,15).
  - Each group tuple is (a,b,c,d) in order.
  - When cnt==ROUNDS-1 completes, copy the result to out_state, set out_valid=1, go to DONE.
- DONE: hold out_valid=1 and out_state stable until out_ready=1. On the handshake, out_valid=0 the next cycle and the FSM returns to IDLE.
- Latency: accept edge to out_valid is exactly ROUNDS cycles (20 by default). Earliest next accept is 1 cycle after the output handshake.
- Throughput: one block per ROUNDS+2 cycles with out_ready held high.
- in_valid during RUN or DONE is ignored (in_ready=0). The upstream must hold in_valid until the handshake.
- out_ready=1 with out_valid=0 has no effect.
- out_state keeps its last value after the handoff until the next completion. It is never updated mid-RUN.
- rst during RUN or DONE aborts the block: no output is produced, all state is cleared as at reset, and the in-flight data is lost.
- Inverse quarter-round, all arithmetic mod 2^32, rotr = rotate right, steps applied in order:
  - b=rotr(b,7)^c; c=c-d
  - d=rotr(d,8)^a; a=a-b
  - b=rotr(b,12)^c; c=c-d
  - d=rotr(d,16)^a; a=a-b
- The inverse quarter-round is the exact inverse of the forward quarter-round already in the codebase. Subtraction wraps with no carry or borrow flag.

Decomposition:
- Shared package chacha20_pkg holds:
  - N=32
  - rotation amounts 16, 12, 8, 7
  - the COLUMN and DIAGONAL index tables (4 groups × 4 indices)
  - the word pack/unpack helper functions (state ↔ 16 words)
  - the ChaCha constants 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574 for benches
- Sub-module chacha20_quarter_inv is purely combinational: a,b,c,d in, a_out..d_out out. It is instantiated 4 times, fed through a mux selected by cnt[0]. This module holds the FSM, counter, working register and handshake.

Test Plan:
- chacha20_quarter_inv standalone: a=0xea2a92f4, b=0xcb1cf8ce, c=0x4581472e, d=0x5881c4bb → 0x11111111, 0x01020304, 0x9b8d6f43, 0x01234567 (RFC 7539 §2.1.1).
- Full block, ROUNDS=20: in_state = RFC 7539 §2.3.2 state after 20 rounds (before feed-forward add), starting 0x837778ab, 0xe238d763… → out_state word0..3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574; word12 = 0x00000001; word13 = 0x09000000. out_valid rises exactly 20 cycles after the accept edge.
- Round-trip: 100 random states pass through the forward chacha20_quarter-based permutation, then this block → out_state == original every time, at any ROUNDS in {2, 8, 20}.
- Backpressure: hold out_ready=0 for 15 cycles after out_valid → out_state and out_valid stay stable, in_ready=0, and a second in_valid pulse is not accepted. Then out_ready=1 for one cycle → out_valid=0 and in_ready=1 on the next cycle.
- Reset mid-op: assert rst on RUN cycle 7 → next cycle out_valid=0, busy=0, out_state=0. A new block is then accepted and completes correctly in 20 cycles.
- All-zero state in → all-zero state out, since zero is a fixed point of the permutation. Latency checks as in scenario 2.
